// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default fetch-unit geometry and the flow-control
// strobe encoding that the control unit and the fetch unit both use.
package cpu_pkg;

  localparam int PC_WIDTH_DEF    = 10;
  localparam int STACK_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    FLOW_SEQ  = 2'd0,
    FLOW_JUMP = 2'd1,
    FLOW_CALL = 2'd2,
    FLOW_RET  = 2'd3
  } flow_e;

  // Collapses the raw strobes to one action; ret beats call beats jump.
  function automatic flow_e flow_decode(input logic ret, input logic call,
                                        input logic jump);
    flow_e f;
    if (ret)       f = FLOW_RET;
    else if (call) f = FLOW_CALL;
    else if (jump) f = FLOW_JUMP;
    else           f = FLOW_SEQ;
    return f;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Hardware return-address LIFO with a saturating depth counter.
// Push is ignored when full, pop is ignored when empty.
module return_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF,
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           push_data_i,
  output logic [WIDTH-1:0]           top_data_o,
  output logic [$clog2(DEPTH):0]     depth_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [AW-1:0]    wr_idx, top_idx;
  logic             do_push, do_pop;

  assign full_o  = (depth_q == DW'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the low bits of depth_q minus one always
  // land on the most recent entry, including when the stack is full.
  assign wr_idx  = depth_q[AW-1:0];
  assign top_idx = depth_q[AW-1:0] - AW'(1);

  assign top_data_o = mem_q[top_idx];
  assign depth_o    = depth_q;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves depth_d unassigned (which would infer a latch).
    depth_d = depth_q;
    if (do_pop)       depth_d = depth_q - DW'(1);
    else if (do_push) depth_d = depth_q + DW'(1);
  end

  // NOTE: entries above depth are never read, so storage needs no reset; only the counter does.
  always_ff @(posedge clk) begin
    if (do_push && !do_pop) mem_q[wr_idx] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and sequencing: next-PC selection (seq/jump/call/ret),
// return-address stack control and sticky overflow/underflow flags.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           jump,
  input  logic                           call,
  input  logic                           ret,
  input  logic [PC_WIDTH-1:0]            target,
  output logic [PC_WIDTH-1:0]            pc,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           err_overflow,
  output logic                           err_underflow
);

  flow_e               flow;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, top_data;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                push, pop, full, empty;

  assign flow   = flow_decode(ret, call, jump);
  assign pc_inc = pc_q + PC_WIDTH'(1);

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (!stall) begin
      unique case (flow)
        FLOW_RET: begin
          // An empty-stack return falls through to the next instruction.
          if (empty) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end else begin
            pc_d = top_data;
            pop  = 1'b1;
          end
        end
        FLOW_CALL: begin
          pc_d = target;
          if (full) ovf_d = 1'b1;
          else      push  = 1'b1;
        end
        FLOW_JUMP: pc_d = target;
        FLOW_SEQ:  pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_inc),
    .top_data_o  (top_data),
    .depth_o     (depth),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign pc            = pc_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequencing, jump, call/ret, stack
// overflow/underflow, PC wrap, stall hold and asynchronous reset.
module tb_pc_fetch_unit;

  localparam int PW = 10;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          reset, stall, jump, call, ret;
  logic [PW-1:0] target;
  logic [PW-1:0] pc;
  logic [2:0]    depth;
  logic          err_overflow, err_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  pc_fetch_unit #(.PC_WIDTH(PW), .STACK_DEPTH(SD)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .jump          (jump),
    .call          (call),
    .ret           (ret),
    .target        (target),
    .pc            (pc),
    .depth         (depth),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #30 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input logic j, input logic c, input logic r,
                         input logic [PW-1:0] t);
    jump = j; call = c; ret = r; target = t;
  endtask

  task automatic expect_state(input string tag, input logic [PW-1:0] epc,
                              input logic [2:0] edep, input logic eovf,
                              input logic eunf);
    check({tag, ".pc"},    32'(pc),            32'(epc));
    check({tag, ".depth"}, 32'(depth),         32'(edep));
    check({tag, ".ovf"},   32'(err_overflow),  32'(eovf));
    check({tag, ".unf"},   32'(err_underflow), 32'(eunf));
  endtask

  // One edge with the given strobes, then strobes return to idle.
  task automatic step(input logic j, input logic c, input logic r,
                      input logic [PW-1:0] t);
    strobes(j, c, r, t);
    tick();
    strobes(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [PW-1:0] ret_addr [4];
    ret_addr[0] = 10'h031; ret_addr[1] = 10'h021;
    ret_addr[2] = 10'h011; ret_addr[3] = 10'h001;

    reset = 1'b1; stall = 1'b0;
    strobes(1'b0, 1'b0, 1'b0, '0);
    repeat (2) tick();
    expect_state("reset", 10'h000, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("seq%0d.pc", i), 32'(pc), i);
    end
    expect_state("seq_end", 10'h005, 3'd0, 1'b0, 1'b0);

    step(1'b1, 1'b0, 1'b0, 10'h003);
    check("to3.pc", 32'(pc), 32'h003);
    step(1'b1, 1'b0, 1'b0, 10'h200);
    expect_state("jump", 10'h200, 3'd0, 1'b0, 1'b0);
    tick();
    check("jump+1.pc", 32'(pc), 32'h201);

    step(1'b1, 1'b0, 1'b0, 10'h007);
    step(1'b0, 1'b1, 1'b0, 10'h100);
    expect_state("call", 10'h100, 3'd1, 1'b0, 1'b0);
    tick(); check("sub1.pc", 32'(pc), 32'h101);
    tick(); check("sub2.pc", 32'(pc), 32'h102);
    step(1'b0, 1'b0, 1'b1, '0);
    expect_state("ret", 10'h008, 3'd0, 1'b0, 1'b0);

    step(1'b1, 1'b0, 1'b0, 10'h3FF);
    check("top.pc", 32'(pc), 32'h3FF);
    tick();
    expect_state("wrap", 10'h000, 3'd0, 1'b0, 1'b0);

    // Nested calls from pc=0; call outranks a simultaneous jump.
    step(1'b1, 1'b1, 1'b0, 10'h010);
    expect_state("nest1", 10'h010, 3'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 10'h020);
    step(1'b0, 1'b1, 1'b0, 10'h030);
    step(1'b0, 1'b1, 1'b0, 10'h040);
    expect_state("nest4", 10'h040, 3'd4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 10'h050);
    expect_state("nest5", 10'h050, 3'd4, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 10'h2AA);
      check($sformatf("pop%0d.pc", i), 32'(pc), 32'(ret_addr[i]));
      check($sformatf("pop%0d.depth", i), 32'(depth), 32'(3 - i));
    end
    step(1'b0, 1'b0, 1'b1, '0);
    expect_state("underflow", 10'h002, 3'd0, 1'b1, 1'b1);

    step(1'b0, 1'b1, 1'b0, 10'h100);
    expect_state("pre_stall", 10'h100, 3'd1, 1'b1, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobes(1'b1, 1'b1, 1'b1, 10'h123);
      tick();
      expect_state($sformatf("stall%0d", i), 10'h100, 3'd1, 1'b1, 1'b1);
    end
    stall = 1'b0;
    strobes(1'b0, 1'b0, 1'b0, '0);

    step(1'b0, 1'b1, 1'b0, 10'h180);
    expect_state("pre_areset", 10'h180, 3'd2, 1'b1, 1'b1);
    #10;
    reset = 1'b1;
    #1;
    expect_state("areset", 10'h000, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    expect_state("after_reset", 10'h001, 3'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
